// File: rtl/alg_pkg.sv
// Types shared with the R-peak detection core.
package alg_pkg;

  localparam int ALG_CTR_WIDTH = 22;

  typedef logic [ALG_CTR_WIDTH-1:0] sample_num_t;

endpackage

// File: rtl/uart_pkg.sv
// Register map, command/status/control layouts and bridge FSM encoding
// shared by the UART register bridge.
package uart_pkg;

  localparam logic [2:0] UART_SR_OFFSET    = 3'd0;
  localparam logic [2:0] UART_CR_OFFSET    = 3'd1;
  localparam logic [2:0] UART_DINL_OFFSET  = 3'd2;
  localparam logic [2:0] UART_DINH_OFFSET  = 3'd3;
  localparam logic [2:0] UART_DOUTL_OFFSET = 3'd4;
  localparam logic [2:0] UART_DOUTM_OFFSET = 3'd5;
  localparam logic [2:0] UART_DOUTH_OFFSET = 3'd6;

  typedef enum logic [1:0] {
    BR_IDLE  = 2'd0,
    BR_WDATA = 2'd1,
    BR_RESP  = 2'd2
  } bridge_state_e;

  localparam logic [1:0] ST_IDLE  = BR_IDLE;
  localparam logic [1:0] ST_WDATA = BR_WDATA;
  localparam logic [1:0] ST_RESP  = BR_RESP;

  typedef struct packed {
    logic [2:0] rsvd;
    logic       timeout_err;
    logic       din_pending;
    logic       overflow;
    logic       fifo_full;
    logic       fifo_empty;
  } uart_sr_t;

  typedef struct packed {
    logic [5:0] rsvd;
    logic       alg_en;
    logic       flush;
  } uart_cr_t;

  typedef struct packed {
    logic [3:0] zero;
    logic [2:0] addr;
    logic       wr;
  } uart_cmd_t;

endpackage

// File: rtl/rpeak_fifo.sv
// Purpose: generic synchronous FIFO with push, pop and flush (flush beats a same-cycle push).
// Latency: a pushed entry is visible at dout the cycle after the push; dout is the head, read combinationally.
// Backpressure: push while full is dropped unless a pop happens that cycle; pop while empty is ignored.
module rpeak_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// Purpose: UART byte command bridge to the R-peak core; UART_BRIDGE_TIMEOUT_EN adds a WDATA timeout.
// Latency: writes/sample_valid 1 cycle after the data byte; tx strobe earliest 1 cycle after a read command.
// Backpressure: tx strobe held off while tx_busy; rx bytes in RESP are ignored; full FIFO drops pushes.
module uart_reg_bridge
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 11,
  parameter int CTR_WIDTH      = alg_pkg::ALG_CTR_WIDTH,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_data_valid,
  input  logic                  tx_busy,
  output logic [DATA_WIDTH-1:0] sample_out,
  output logic                  sample_valid,
  output logic                  alg_en,
  input  logic [CTR_WIDTH-1:0]  rpeak_sample_num,
  input  logic                  rpeak_valid
);

  logic [1:0]           state;
  logic [2:0]           addr_q;
  logic [7:0]           resp_q;
  logic [7:0]           resp_byte;
  uart_cmd_t            cmd;
  uart_cr_t             cr_q;
  uart_sr_t             sr;
  logic [7:0]           dinl;
  logic                 din_pending;
  logic [23:0]          hold;
  logic                 hold_valid;
  logic                 overflow;
  logic                 timeout_err;
  logic                 timeout_fire;
  logic                 cmd_ok, rd_cmd, wr_cmd, wr_fire;
  logic                 flush, pop;
  logic                 fifo_full, fifo_empty;
  logic [CTR_WIDTH-1:0] fifo_dout;
  logic [23:0]          head24;

  assign cmd     = uart_cmd_t'(rx_data);
  assign cmd_ok  = rx_data_valid && (state == ST_IDLE) && (cmd.zero == 4'h0);
  assign rd_cmd  = cmd_ok && !cmd.wr;
  assign wr_cmd  = cmd_ok && cmd.wr;
  assign wr_fire = rx_data_valid && (state == ST_WDATA);
  assign flush   = wr_fire && (addr_q == UART_CR_OFFSET) && rx_data[0];
  assign pop     = rd_cmd && (cmd.addr == UART_DOUTH_OFFSET) && hold_valid;
  assign head24  = 24'(fifo_dout);

  assign tx_data       = resp_q;
  assign tx_data_valid = (state == ST_RESP) && !tx_busy;
  assign alg_en        = cr_q.alg_en;

  rpeak_fifo #(
    .WIDTH (CTR_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rpeak_valid),
    .pop   (pop),
    .flush (flush),
    .din   (rpeak_sample_num),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    sr             = '0;
    sr.fifo_empty  = fifo_empty;
    sr.fifo_full   = fifo_full;
    sr.overflow    = overflow;
    sr.din_pending = din_pending;
    sr.timeout_err = timeout_err;
  end

  // DOUTL answers with the head it is about to load into hold, not the stale hold.
  always_comb begin
    resp_byte = 8'h00;
    case (cmd.addr)
      UART_SR_OFFSET:    resp_byte = sr;
      UART_CR_OFFSET:    resp_byte = cr_q;
      UART_DOUTL_OFFSET: resp_byte = fifo_empty ? 8'h00 : head24[7:0];
      UART_DOUTM_OFFSET: resp_byte = hold[15:8];
      UART_DOUTH_OFFSET: resp_byte = hold[23:16];
      default:           resp_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      addr_q <= '0;
      resp_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_cmd) begin
            state  <= ST_WDATA;
            addr_q <= cmd.addr;
          end else if (rd_cmd) begin
            state  <= ST_RESP;
            resp_q <= resp_byte;
          end
        end
        ST_WDATA: if (wr_fire || timeout_fire) state <= ST_IDLE;
        ST_RESP:  if (!tx_busy) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cr_q         <= '0;
      dinl         <= '0;
      din_pending  <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      hold         <= '0;
      hold_valid   <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (wr_fire) begin
        case (addr_q)
          UART_CR_OFFSET: cr_q <= uart_cr_t'({rx_data[7:1], 1'b0});
          UART_DINL_OFFSET: begin
            dinl        <= rx_data;
            din_pending <= 1'b1;
          end
          UART_DINH_OFFSET: begin
            din_pending <= 1'b0;
            if (cr_q.alg_en) begin
              sample_out   <= {rx_data[DATA_WIDTH-9:0], dinl};
              sample_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (rd_cmd) begin
        case (cmd.addr)
          UART_SR_OFFSET: overflow <= 1'b0;
          UART_DOUTL_OFFSET: begin
            hold       <= fifo_empty ? 24'h0 : head24;
            hold_valid <= !fifo_empty;
          end
          UART_DOUTH_OFFSET: hold_valid <= 1'b0;
          default: ;
        endcase
      end
      // A fresh drop wins over a same-cycle SR read so it is not lost.
      if (rpeak_valid && fifo_full && !pop) overflow <= 1'b1;
      if (flush) begin
        hold_valid <= 1'b0;
        overflow   <= 1'b0;
      end
    end
  end

`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  assign timeout_fire = (state == ST_WDATA) && !rx_data_valid &&
                        (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if ((state == ST_WDATA) && !rx_data_valid && !timeout_fire) to_cnt <= to_cnt + TO_W'(1);
      else to_cnt <= '0;
      if (timeout_fire) timeout_err <= 1'b1;
      if (rd_cmd && (cmd.addr == UART_SR_OFFSET)) timeout_err <= 1'b0;
    end
  end
`else
  assign timeout_fire = 1'b0;
  assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed bench for uart_reg_bridge; build with UART_BRIDGE_TIMEOUT_EN to cover the WDATA timeout.
module tb_uart_reg_bridge;

  localparam int TO_CYC = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_data_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_busy = 1'b0;
  logic [10:0] sample_out;
  logic        sample_valid;
  logic        alg_en;
  logic [21:0] rpeak_sample_num = '0;
  logic        rpeak_valid = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_reg_bridge #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_data          (rx_data),
    .rx_data_valid    (rx_data_valid),
    .tx_data          (tx_data),
    .tx_data_valid    (tx_data_valid),
    .tx_busy          (tx_busy),
    .sample_out       (sample_out),
    .sample_valid     (sample_valid),
    .alg_en           (alg_en),
    .rpeak_sample_num (rpeak_sample_num),
    .rpeak_valid      (rpeak_valid)
  );

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b;
    rx_data_valid = 1'b1;
    @(posedge clk); #1;
    rx_data_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
    send_byte({4'h0, a, 1'b1});
    send_byte(d);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [7:0] b, output bit got);
    b = 8'h00;
    got = 1'b0;
    send_byte({4'h0, a, 1'b0});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx_data_valid) begin
        b = tx_data;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic push(input logic [21:0] v);
    @(posedge clk); #1;
    rpeak_sample_num = v;
    rpeak_valid = 1'b1;
    @(posedge clk); #1;
    rpeak_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] b;
    bit got;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({tx_data_valid, sample_valid, alg_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b expected 000", {tx_data_valid, sample_valid, alg_en});
    end
    n_checks++;
    if ({tx_data, sample_out} !== 19'h0) begin
      n_fail++; $display("FAIL reset_data: got tx %h sample %h expected 0", tx_data, sample_out);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    write_reg(3'd1, 8'h02);
    @(negedge clk);
    n_checks++;
    if (alg_en !== 1'b1) begin
      n_fail++; $display("FAIL reset_pre_alg_en: got %b expected 1", alg_en);
    end
    send_byte(8'h03);
    #2 rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({tx_data_valid, sample_valid, alg_en, tx_data} !== 11'h0) begin
      n_fail++; $display("FAIL reset_in_wdata: got %h expected 0", {tx_data_valid, sample_valid, alg_en, tx_data});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h01) begin
      n_fail++; $display("FAIL reset_next_cmd: got %h strobe %0b expected 01", b, got);
    end
  endtask

  task automatic test_sample();
    logic [7:0] b;
    bit got;
    write_reg(3'd1, 8'h02);
    write_reg(3'd2, 8'hF3);
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h09) begin
      n_fail++; $display("FAIL sample_sr_pending: got %h strobe %0b expected 09", b, got);
    end
    send_byte(8'h07);
    send_byte(8'h03);
    @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b1 || sample_out !== 11'h3F3) begin
      n_fail++; $display("FAIL sample_out: got %b/%h expected 1/3f3", sample_valid, sample_out);
    end
    @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b0) begin
      n_fail++; $display("FAIL sample_pulse_width: got %b expected 0", sample_valid);
    end
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h01) begin
      n_fail++; $display("FAIL sample_sr_after: got %h strobe %0b expected 01", b, got);
    end
  endtask

  task automatic test_sample_disabled();
    logic [7:0] b;
    bit got;
    bit seen;
    write_reg(3'd1, 8'h00);
    @(negedge clk);
    n_checks++;
    if (alg_en !== 1'b0) begin
      n_fail++; $display("FAIL dis_alg_en: got %b expected 0", alg_en);
    end
    write_reg(3'd2, 8'h11);
    send_byte(8'h07);
    send_byte(8'h05);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL dis_no_sample: got %b expected 0", seen);
    end
    write_reg(3'd1, 8'h02);
    send_byte(8'h07);
    send_byte(8'h05);
    @(negedge clk);
    n_checks++;
    if (sample_valid !== 1'b1 || sample_out !== 11'h511) begin
      n_fail++; $display("FAIL reuse_dinl: got %b/%h expected 1/511", sample_valid, sample_out);
    end
    read_reg(3'd1, b, got);
    n_checks++;
    if (!got || b !== 8'h02) begin
      n_fail++; $display("FAIL cr_readback: got %h strobe %0b expected 02", b, got);
    end
  endtask

  task automatic test_readback();
    logic [2:0] ra [5] = '{3'd0, 3'd4, 3'd5, 3'd6, 3'd0};
    logic [7:0] ex [5] = '{8'h00, 8'hDE, 8'hBC, 8'h2A, 8'h01};
    logic [7:0] b;
    bit got;
    push(22'h2ABCDE);
    for (int i = 0; i < 5; i++) begin
      read_reg(ra[i], b, got);
      n_checks++;
      if (!got || b !== ex[i]) begin
        n_fail++; $display("FAIL readback[%0d]: got %h strobe %0b expected %h", i, b, got, ex[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] v;
    logic [7:0] b;
    bit got;
    for (int i = 0; i < 17; i++) push(22'(24'h030000 + 24'(i) * 24'h010203));
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h06) begin
      n_fail++; $display("FAIL ovf_sr1: got %h strobe %0b expected 06", b, got);
    end
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h02) begin
      n_fail++; $display("FAIL ovf_sr2: got %h strobe %0b expected 02", b, got);
    end
    for (int i = 0; i < 16; i++) begin
      v = 24'h030000 + 24'(i) * 24'h010203;
      for (int k = 0; k < 3; k++) begin
        read_reg(3'(4 + k), b, got);
        n_checks++;
        if (!got || b !== v[8*k +: 8]) begin
          n_fail++; $display("FAIL ovf_entry[%0d][%0d]: got %h strobe %0b expected %h", i, k, b, got, v[8*k +: 8]);
        end
      end
    end
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h01) begin
      n_fail++; $display("FAIL ovf_sr_end: got %h strobe %0b expected 01", b, got);
    end
  endtask

  task automatic test_flush();
    logic [2:0] ra [8] = '{3'd0, 3'd1, 3'd6, 3'd0, 3'd4, 3'd5, 3'd6, 3'd0};
    logic [7:0] ex [8] = '{8'h01, 8'h02, 8'h01, 8'h00, 8'hFE, 8'h0F, 8'h3C, 8'h01};
    logic [7:0] b;
    bit got;
    push(22'h012345);
    push(22'h00ABCD);
    read_reg(3'd4, b, got);
    n_checks++;
    if (!got || b !== 8'h45) begin
      n_fail++; $display("FAIL flush_doutl: got %h strobe %0b expected 45", b, got);
    end
    send_byte(8'h03);
    @(posedge clk); #1;
    rx_data = 8'h03; rx_data_valid = 1'b1;
    rpeak_sample_num = 22'h111111; rpeak_valid = 1'b1;
    @(posedge clk); #1;
    rx_data_valid = 1'b0; rpeak_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) push(22'h3C0FFE);
      read_reg(ra[i], b, got);
      n_checks++;
      if (!got || b !== ex[i]) begin
        n_fail++; $display("FAIL flush[%0d]: got %h strobe %0b expected %h", i, b, got, ex[i]);
      end
    end
  endtask

  task automatic test_tx_busy();
    bit seen;
    tx_busy = 1'b1;
    send_byte(8'h00);
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (tx_data_valid) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL busy_hold: got strobe %b expected 0", seen);
    end
    @(posedge clk); #1;
    tx_busy = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tx_data_valid !== 1'b1 || tx_data !== 8'h01) begin
      n_fail++; $display("FAIL busy_release: got %b/%h expected 1/01", tx_data_valid, tx_data);
    end
    @(negedge clk);
    n_checks++;
    if (tx_data_valid !== 1'b0) begin
      n_fail++; $display("FAIL busy_pulse_width: got %b expected 0", tx_data_valid);
    end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] b;
    bit got;
    send_byte(8'h13);
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h01) begin
      n_fail++; $display("FAIL bad_cmd_next: got %h strobe %0b expected 01", b, got);
    end
    n_checks++;
    if (alg_en !== 1'b1) begin
      n_fail++; $display("FAIL bad_cmd_alg_en: got %b expected 1", alg_en);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    bit got;
`ifdef UART_BRIDGE_TIMEOUT_EN
    send_byte(8'h03);
    repeat (TO_CYC + 5) @(posedge clk);
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h11) begin
      n_fail++; $display("FAIL timeout_sr: got %h strobe %0b expected 11", b, got);
    end
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h01) begin
      n_fail++; $display("FAIL timeout_sr_clear: got %h strobe %0b expected 01", b, got);
    end
    n_checks++;
    if (alg_en !== 1'b1) begin
      n_fail++; $display("FAIL timeout_discard: got %b expected 1", alg_en);
    end
`else
    send_byte(8'h03);
    repeat (100) @(posedge clk);
    send_byte(8'h06);
    read_reg(3'd1, b, got);
    n_checks++;
    if (!got || b !== 8'h06) begin
      n_fail++; $display("FAIL wdata_wait: got %h strobe %0b expected 06", b, got);
    end
    read_reg(3'd0, b, got);
    n_checks++;
    if (!got || b !== 8'h01) begin
      n_fail++; $display("FAIL wdata_sr: got %h strobe %0b expected 01", b, got);
    end
    write_reg(3'd1, 8'h02);
`endif
  endtask

  initial begin
    test_reset();
    test_sample();
    test_sample_disabled();
    test_readback();
    test_overflow();
    test_flush();
    test_tx_busy();
    test_bad_cmd();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
